trap_controller: RTL

- Trap initiator for the core. Collects synchronous exceptions from the pipeline and interrupt requests, and selects one by fixed priority.
- Freezes and flushes the pipeline, then drives the csr_file context-switch inputs (CS, CAUSE, NPC).
- After that, signals the fetch stage to redirect to the trap vector that csr_file returns on PC_OUT.

---
 rtl/trap_pkg.sv | 51 +++++
 rtl/trap_prio_enc.sv | 50 +++++
 rtl/trap_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// ============================================================================
// Module  : trap_pkg
// Brief   : Shared states, cause codes and fixed priority tables for the trap
//           initiator.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [5:0] EXC_INSTR_MISALIGN = 6'd0;
  localparam logic [5:0] EXC_INSTR_FAULT    = 6'd1;
  localparam logic [5:0] EXC_ILLEGAL        = 6'd2;
  localparam logic [5:0] EXC_BREAKPOINT     = 6'd3;
  localparam logic [5:0] EXC_LOAD_MISALIGN  = 6'd4;
  localparam logic [5:0] EXC_LOAD_FAULT     = 6'd5;
  localparam logic [5:0] EXC_STORE_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_STORE_FAULT    = 6'd7;
  localparam logic [5:0] EXC_ECALL_BASE     = 6'd8;

  localparam logic [5:0] IRQ_SW    = 6'd3;
  localparam logic [5:0] IRQ_TIMER = 6'd7;
  localparam logic [5:0] IRQ_EXT   = 6'd11;
  localparam logic [5:0] IRQ_NMI   = 6'd0;

  // Exception priority, highest first; slot value 8 stands for ECALL.
  localparam int         EXC_PRIO_N = 9;
  localparam logic [3:0] ECALL_SLOT = 4'd8;
  localparam logic [3:0] EXC_PRIO [EXC_PRIO_N] =
    '{4'd3, 4'd1, 4'd0, 4'd2, 4'd8, 4'd4, 4'd6, 4'd5, 4'd7};

  // Interrupt priority, highest first: IRQ line index and its cause code.
  localparam int         IRQ_PRIO_N = 3;
  localparam logic [1:0] IRQ_PRIO_LINE [IRQ_PRIO_N] = '{2'd2, 2'd0, 2'd1};
  localparam logic [5:0] IRQ_PRIO_CODE [IRQ_PRIO_N] = '{IRQ_EXT, IRQ_SW, IRQ_TIMER};

  // Interrupt flag lives in the MSB of CAUSE.
  function automatic int int_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_prio_enc.sv
// ============================================================================
// Module  : trap_prio_enc
// Brief   : Combinational fixed-priority selector over exceptions, ECALL and
//           qualified interrupts; any exception beats any interrupt.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_prio_enc
  import trap_pkg::*;
(
  input  logic [7:0] exc_vec,
  input  logic       ecall,
  input  logic [2:0] irq,
  input  logic [1:0] cur_priv,
  output logic       valid,
  output logic       is_irq,
  output logic [5:0] code
);

  logic hit;

  // Scan lowest priority first so the highest-priority hit is written last.
  always_comb begin
    valid  = 1'b0;
    is_irq = 1'b0;
    code   = '0;
    hit    = 1'b0;
    for (int i = IRQ_PRIO_N - 1; i >= 0; i--) begin
      if (irq[IRQ_PRIO_LINE[i]]) begin
        valid  = 1'b1;
        is_irq = 1'b1;
        code   = IRQ_PRIO_CODE[i];
      end
    end
    for (int i = EXC_PRIO_N - 1; i >= 0; i--) begin
      if (EXC_PRIO[i] == ECALL_SLOT) hit = ecall;
      else                           hit = exc_vec[EXC_PRIO[i][2:0]];
      if (hit) begin
        valid  = 1'b1;
        is_irq = 1'b0;
        code   = (EXC_PRIO[i] == ECALL_SLOT) ? EXC_ECALL_BASE + {4'b0, cur_priv}
                                             : {2'b0, EXC_PRIO[i]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
// Module  : trap_controller
// Brief   : Trap initiator: captures the winning event, stalls and flushes the
//           pipeline, strobes the csr_file context switch, then redirects fetch.
//           Optional unmaskable NMI input guarded by macro TRAP_NMI_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_controller
  import trap_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [7:0]      EXC_VEC,
  input  logic            ECALL,
  input  logic [XLEN-1:0] EXC_PC,
  input  logic [XLEN-1:0] NEXT_PC,
  input  logic [2:0]      IRQ_PEND,
  input  logic [2:0]      IRQ_EN,
  input  logic            GLOBAL_IE,
  input  logic [1:0]      CUR_PRIV,
  input  logic            DRAIN_DONE,
`ifdef TRAP_NMI_EN
  input  logic            NMI,
  output logic            NMI_SEEN,
`endif
  output logic            STALL,
  output logic            FLUSH,
  output logic            CS,
  output logic [XLEN-1:0] CAUSE,
  output logic [XLEN-1:0] NPC,
  output logic            REDIRECT,
  output logic            BUSY
);

  trap_state_e     state, state_next;
  logic [CNT_W-1:0] drain_cnt;
  logic            flush_q;
  logic            capture;
  logic [2:0]      irq_qual;
  logic            enc_valid, enc_is_irq;
  logic [5:0]      enc_code;
  logic            ev_valid, ev_is_irq;
  logic [5:0]      ev_code;
  logic [XLEN-1:0] cause_next;

  assign irq_qual = IRQ_PEND & IRQ_EN & {3{GLOBAL_IE}};

  trap_prio_enc u_prio_enc (
    .exc_vec  (EXC_VEC),
    .ecall    (ECALL),
    .irq      (irq_qual),
    .cur_priv (CUR_PRIV),
    .valid    (enc_valid),
    .is_irq   (enc_is_irq),
    .code     (enc_code)
  );

`ifdef TRAP_NMI_EN
  logic nmi_seen_q;
  assign ev_valid  = NMI | enc_valid;
  assign ev_is_irq = NMI | enc_is_irq;
  assign ev_code   = NMI ? IRQ_NMI : enc_code;
  assign NMI_SEEN  = nmi_seen_q;
`else
  assign ev_valid  = enc_valid;
  assign ev_is_irq = enc_is_irq;
  assign ev_code   = enc_code;
`endif

  always_comb begin
    cause_next                = '0;
    cause_next[int_bit(XLEN)] = ev_is_irq;
    cause_next[5:0]           = ev_code;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ev_valid) begin
          capture    = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (DRAIN_DONE || drain_cnt == CNT_W'(DRAIN_TIMEOUT - 1))
          state_next = S_COMMIT;
      end
      S_COMMIT:   state_next = S_REDIRECT;
      S_REDIRECT: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      flush_q   <= 1'b0;
      drain_cnt <= '0;
      CAUSE     <= '0;
      NPC       <= '0;
    end else begin
      state   <= state_next;
      flush_q <= capture;
      if (capture) begin
        drain_cnt <= '0;
        CAUSE     <= cause_next;
        NPC       <= ev_is_irq ? NEXT_PC : EXC_PC;
      end else if (state == S_DRAIN && drain_cnt != {CNT_W{1'b1}}) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

`ifdef TRAP_NMI_EN
  always_ff @(posedge CLK) begin
    if (RESET)                nmi_seen_q <= 1'b0;
    else if (capture && NMI)  nmi_seen_q <= 1'b1;
  end
`endif

  assign STALL    = (state != S_IDLE);
  assign BUSY     = (state != S_IDLE);
  assign FLUSH    = flush_q;
  assign CS       = (state == S_COMMIT);
  assign REDIRECT = (state == S_REDIRECT);

endmodule

`default_nettype wire
